// File: rtl/counter_pkg.sv
// Shared constants, types and state encoding for the counter_b32 checker.
package counter_pkg;

   localparam int NIB_W   = 4;
   localparam int NUM_NIB = 8;

   localparam logic [1:0] MODE_UP  = 2'b00;
   localparam logic [1:0] MODE_DN  = 2'b01;
   localparam logic [1:0] MODE_DN3 = 2'b10;
   localparam logic [1:0] MODE_LD  = 2'b11;

   typedef logic [NIB_W-1:0] nib_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      CHECK = 2'd2,
      FAIL  = 2'd3
   } chk_state_t;

endpackage

// File: rtl/counter_nib_model.sv
// Reference next-state function of one 4-bit counter slice and the compare
// of the observed slice outputs against the current model value.
module counter_nib_model
   import counter_pkg::*;
(
   input  logic       mon_enable,
   input  logic       mon_reset,
   input  logic [1:0] mon_mode,
   input  nib_t       mon_d,
   input  nib_t       mon_q,
   input  logic       mon_rco,
   input  logic       mon_load,
   input  nib_t       exp_q,
   input  logic       exp_rco,
   input  logic       exp_load,
   output nib_t       next_q,
   output logic       next_rco,
   output logic       next_load,
   output logic       mismatch
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      next_q    = exp_q;
      next_rco  = 1'b0;
      next_load = 1'b0;
      if (mon_reset) begin
         next_q = '0;
      end else if (mon_enable) begin
         unique case (mon_mode)
            MODE_UP: begin
               next_q   = exp_q + 4'd1;
               next_rco = (exp_q == 4'd15);
            end
            MODE_DN: begin
               next_q   = exp_q - 4'd1;
               next_rco = (exp_q == 4'd0);
            end
            MODE_DN3: begin
               next_q   = exp_q - 4'd3;
               next_rco = (exp_q < 4'd3);
            end
            default: begin
               next_q    = mon_d;
               next_load = 1'b1;
            end
         endcase
      end
   end

   assign mismatch = (mon_q != exp_q) | (mon_rco != exp_rco) | (mon_load != exp_load);

endmodule

// File: rtl/counter_b32_checker.sv
// Passive checker for counter_b32: keeps a per-nibble model, aligns it on a
// reset or load, then reports per-nibble mismatches, an error count and a sticky fail.
module counter_b32_checker
   import counter_pkg::*;
#(
   parameter int ERR_CNT_W   = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic                 chk_clk,
   input  logic                 chk_reset,
   input  logic                 chk_en,
   input  logic                 mon_enable,
   input  logic                 mon_reset,
   input  logic [1:0]           mon_mode,
   input  logic [31:0]          mon_D,
   input  logic [31:0]          mon_Q,
   input  logic [7:0]           mon_rco,
   input  logic [7:0]           mon_load,
   output logic                 chk_synced,
   output logic                 chk_err,
   output logic [7:0]           chk_err_mask,
   output logic [ERR_CNT_W-1:0] chk_err_cnt,
   output logic                 chk_fail
);

   chk_state_t state, state_next;

   logic [31:0] exp_q, next_q;
   logic [7:0]  exp_rco, exp_load, next_rco, next_load, mismatch;
   logic        compare, any_mismatch, sync_evt;

   for (genvar g = 0; g < NUM_NIB; g++) begin : g_nib
      counter_nib_model u_nib (
         .mon_enable (mon_enable),
         .mon_reset  (mon_reset),
         .mon_mode   (mon_mode),
         .mon_d      (mon_D[g*NIB_W +: NIB_W]),
         .mon_q      (mon_Q[g*NIB_W +: NIB_W]),
         .mon_rco    (mon_rco[g]),
         .mon_load   (mon_load[g]),
         .exp_q      (exp_q[g*NIB_W +: NIB_W]),
         .exp_rco    (exp_rco[g]),
         .exp_load   (exp_load[g]),
         .next_q     (next_q[g*NIB_W +: NIB_W]),
         .next_rco   (next_rco[g]),
         .next_load  (next_load[g]),
         .mismatch   (mismatch[g])
      );
   end

   assign compare      = (state == CHECK) && chk_en;
   assign any_mismatch = compare && (|mismatch);
   // Only a reset or a load gives the model a value independent of its unknown past.
   assign sync_evt     = mon_reset || (mon_enable && (mon_mode == MODE_LD));

   always_ff @(posedge chk_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (chk_reset) state <= IDLE;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!chk_en) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    state_next = ARMED;
            ARMED:   if (sync_evt) state_next = CHECK;
            CHECK:   if (STOP_ON_ERR && any_mismatch) state_next = FAIL;
            default: state_next = FAIL;
         endcase
      end
   end

   always_comb begin
      chk_synced = (state == CHECK);
   end

   always_ff @(posedge chk_clk) begin
      if (chk_reset) begin
         exp_q    <= '0;
         exp_rco  <= '0;
         exp_load <= '0;
      end else if (state == ARMED || state == CHECK) begin
         exp_q    <= next_q;
         exp_rco  <= next_rco;
         exp_load <= next_load;
      end
   end

   always_ff @(posedge chk_clk) begin
      if (chk_reset) begin
         chk_err      <= 1'b0;
         chk_err_mask <= '0;
         chk_err_cnt  <= '0;
         chk_fail     <= 1'b0;
      end else begin
         chk_err      <= any_mismatch;
         chk_err_mask <= compare ? mismatch : 8'h00;
         if (any_mismatch) begin
            chk_fail <= 1'b1;
            if (chk_err_cnt != '1) chk_err_cnt <= chk_err_cnt + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_counter_b32_checker.sv
// Bench for counter_b32_checker: hand-derived vector table, two corner-case
// sequences and random traffic against a behavioural model of counter and checker.
module tb_counter_b32_checker;

   typedef struct {
      bit        en_chk;
      bit        rst_chk;
      bit        en;
      bit        rst;
      bit [1:0]  mode;
      bit [31:0] d;
      bit [31:0] q;
      bit [7:0]  rco;
      bit [7:0]  load;
      bit        x_err;
      bit [7:0]  x_mask;
      bit        x_synced;
   } vec_t;

   logic        chk_clk = 1'b0;
   logic        chk_reset = 1'b1, chk_en = 1'b0;
   logic        mon_enable = 1'b0, mon_reset = 1'b0;
   logic [1:0]  mon_mode = 2'b00;
   logic [31:0] mon_D = '0, mon_Q = '0;
   logic [7:0]  mon_rco = '0, mon_load = '0;

   logic        synced[3], err[3], fail[3];
   logic [7:0]  mask[3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: golden counter value per nibble, plus checker view.
   int       g_q[8];
   bit [7:0] g_rco, g_load;
   bit       r_armed[3], r_synced[3], r_stopped[3], r_err[3], r_fail[3];
   bit [7:0] r_mask[3];
   int       r_cnt[3];

   always #5 chk_clk = ~chk_clk;

   counter_b32_checker #(.ERR_CNT_W(16), .STOP_ON_ERR(1'b0)) u_dut0 (
      .chk_clk(chk_clk), .chk_reset(chk_reset), .chk_en(chk_en),
      .mon_enable(mon_enable), .mon_reset(mon_reset), .mon_mode(mon_mode),
      .mon_D(mon_D), .mon_Q(mon_Q), .mon_rco(mon_rco), .mon_load(mon_load),
      .chk_synced(synced[0]), .chk_err(err[0]), .chk_err_mask(mask[0]),
      .chk_err_cnt(cnt0), .chk_fail(fail[0]));

   counter_b32_checker #(.ERR_CNT_W(16), .STOP_ON_ERR(1'b1)) u_dut1 (
      .chk_clk(chk_clk), .chk_reset(chk_reset), .chk_en(chk_en),
      .mon_enable(mon_enable), .mon_reset(mon_reset), .mon_mode(mon_mode),
      .mon_D(mon_D), .mon_Q(mon_Q), .mon_rco(mon_rco), .mon_load(mon_load),
      .chk_synced(synced[1]), .chk_err(err[1]), .chk_err_mask(mask[1]),
      .chk_err_cnt(cnt1), .chk_fail(fail[1]));

   counter_b32_checker #(.ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) u_dut2 (
      .chk_clk(chk_clk), .chk_reset(chk_reset), .chk_en(chk_en),
      .mon_enable(mon_enable), .mon_reset(mon_reset), .mon_mode(mon_mode),
      .mon_D(mon_D), .mon_Q(mon_Q), .mon_rco(mon_rco), .mon_load(mon_load),
      .chk_synced(synced[2]), .chk_err(err[2]), .chk_err_mask(mask[2]),
      .chk_err_cnt(cnt2), .chk_fail(fail[2]));

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit en_chk, input bit rst_chk, input bit en, input bit rst,
                               input bit [1:0] mode, input bit [31:0] d, input bit [31:0] q,
                               input bit [7:0] rco, input bit [7:0] load, input bit x_err,
                               input bit [7:0] x_mask, input bit x_synced);
      vec_t v;
      v.en_chk = en_chk; v.rst_chk = rst_chk; v.en = en; v.rst = rst; v.mode = mode;
      v.d = d; v.q = q; v.rco = rco; v.load = load;
      v.x_err = x_err; v.x_mask = x_mask; v.x_synced = x_synced;
      return v;
   endfunction

   function automatic bit [31:0] g_pack();
      bit [31:0] r = '0;
      for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(g_q[i]);
      return r;
   endfunction

   function automatic int cnt_of(input int u);
      if (u == 0) return int'(cnt0);
      if (u == 1) return int'(cnt1);
      return int'(cnt2);
   endfunction

   // Advance the checker view and the golden counter by one clock.
   task automatic model_edge(input vec_t v);
      bit [7:0] mm = '0;
      for (int i = 0; i < 8; i++)
         mm[i] = (int'(v.q[i*4 +: 4]) != g_q[i]) || (v.rco[i] != g_rco[i]) || (v.load[i] != g_load[i]);
      for (int u = 0; u < 3; u++) begin
         if (v.rst_chk) begin
            r_armed[u] = 0; r_synced[u] = 0; r_stopped[u] = 0;
            r_err[u] = 0; r_mask[u] = 0; r_cnt[u] = 0; r_fail[u] = 0;
         end else begin
            r_mask[u] = (r_synced[u] && v.en_chk) ? mm : 8'h00;
            r_err[u]  = (r_mask[u] != 0);
            if (r_err[u]) begin
               r_fail[u] = 1;
               if (r_cnt[u] < ((u == 2) ? 3 : 65535)) r_cnt[u]++;
            end
            if (!v.en_chk) begin
               r_armed[u] = 0; r_synced[u] = 0; r_stopped[u] = 0;
            end else if (r_synced[u]) begin
               if (r_err[u] && u == 1) begin
                  r_synced[u] = 0; r_stopped[u] = 1;
               end
            end else if (r_armed[u] && !r_stopped[u]) begin
               if (v.rst || (v.en && v.mode == 2'b11)) begin
                  r_armed[u] = 0; r_synced[u] = 1;
               end
            end else if (!r_stopped[u]) begin
               r_armed[u] = 1;
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         g_rco[i] = 0; g_load[i] = 0;
         if (v.rst) g_q[i] = 0;
         else if (v.en) begin
            case (v.mode)
               2'b00: begin g_rco[i] = (g_q[i] == 15); g_q[i] = (g_q[i] + 1) % 16; end
               2'b01: begin g_rco[i] = (g_q[i] == 0);  g_q[i] = (g_q[i] + 15) % 16; end
               2'b10: begin g_rco[i] = (g_q[i] < 3);   g_q[i] = (g_q[i] + 13) % 16; end
               default: begin g_q[i] = int'(v.d[i*4 +: 4]); g_load[i] = 1; end
            endcase
         end
      end
   endtask

   task automatic step(input vec_t v);
      @(negedge chk_clk);
      chk_en = v.en_chk; chk_reset = v.rst_chk;
      mon_enable = v.en; mon_reset = v.rst; mon_mode = v.mode;
      mon_D = v.d; mon_Q = v.q; mon_rco = v.rco; mon_load = v.load;
      model_edge(v);
      @(posedge chk_clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         check($sformatf("err[%0d]", u), err[u], r_err[u]);
         check($sformatf("mask[%0d]", u), mask[u], r_mask[u]);
         check($sformatf("synced[%0d]", u), synced[u], r_synced[u]);
         check($sformatf("fail[%0d]", u), fail[u], r_fail[u]);
         check($sformatf("cnt[%0d]", u), cnt_of(u), r_cnt[u]);
      end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      bit [31:0] fq;
      bit [7:0]  fr, fl;

      for (int i = 0; i < 8; i++) g_q[i] = 0;
      g_rco = 0; g_load = 0;

      tbl.push_back(mk(0,1, 0,0,2'd0, 32'h0, 32'h0,        8'h00,8'h00, 0,8'h00,0));
      tbl.push_back(mk(1,0, 0,0,2'd0, 32'h0, 32'hDEADBEEF, 8'h00,8'h00, 0,8'h00,0));
      tbl.push_back(mk(1,0, 0,1,2'd0, 32'h0, 32'hDEADBEEF, 8'hFF,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd0, 32'h0, 32'h00000000, 8'h00,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd0, 32'h0, 32'h11111111, 8'h00,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd3, 32'h12345678, 32'h22222222, 8'h00,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd2, 32'h0, 32'h12345678, 8'h00,8'hFF, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd2, 32'h0, 32'hEF012345, 8'hC0,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd2, 32'h0, 32'hBCDEF012, 8'h38,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 0,0,2'd1, 32'h0, 32'h89ABCDEF, 8'h07,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 0,0,2'd1, 32'h0, 32'h89ABCDEF, 8'h00,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 0,0,2'd1, 32'h0, 32'h89ABCDEF, 8'h04,8'h00, 1,8'h04,1));
      tbl.push_back(mk(1,0, 1,0,2'd1, 32'h0, 32'h89ABCDEF, 8'h00,8'h00, 0,8'h00,1));
      tbl.push_back(mk(1,0, 1,0,2'd0, 32'h0, 32'h789ABC0E, 8'h00,8'h00, 1,8'h02,1));
      tbl.push_back(mk(1,0, 1,0,2'd0, 32'h0, 32'h89ABCDEF, 8'h00,8'h01, 1,8'h01,1));
      tbl.push_back(mk(0,0, 0,0,2'd0, 32'h0, 32'h9ABCDEF0, 8'h01,8'h00, 0,8'h00,0));

      foreach (tbl[k]) begin
         step(tbl[k]);
         check($sformatf("tbl%0d_err", k), err[0], tbl[k].x_err);
         check($sformatf("tbl%0d_mask", k), mask[0], tbl[k].x_mask);
         check($sformatf("tbl%0d_synced", k), synced[0], tbl[k].x_synced);
         if (k == 14) begin
            check("tbl_cnt_run", cnt0, 3);
            check("tbl_cnt_stop", cnt1, 1);
            check("tbl_synced_stop", synced[1], 0);
            check("tbl_cnt_sat", cnt2, 3);
         end
      end

      // Up-count over a full wrap after a counter reset.
      step(mk(1,0, 0,0,2'd0, 32'h0, g_pack(), g_rco, g_load, 0,0,0));
      step(mk(1,0, 0,1,2'd0, 32'h0, 32'h0, 8'h00, 8'h00, 0,0,1));
      for (int k = 0; k < 20; k++) begin
         fq = {8{4'(k % 16)}};
         fr = (k == 16) ? 8'hFF : 8'h00;
         step(mk(1,0, 1,0,2'd0, 32'h0, fq, fr, 8'h00, 0,0,1));
         check($sformatf("up%0d_err", k), err[0], 0);
         check($sformatf("up%0d_synced", k), synced[0], 1);
      end

      // Continuous faults saturate the narrow counter; chk_reset then clears it.
      for (int k = 0; k < 5; k++)
         step(mk(1,0, 1,0,2'd0, 32'h0, g_pack() ^ 32'h0000_0010, g_rco, g_load, 0,0,0));
      check("sat_cnt", cnt2, 3);
      check("sat_mask", mask[2], 8'h02);
      step(mk(1,1, 1,0,2'd0, 32'h0, g_pack() ^ 32'h0000_0010, g_rco, g_load, 0,0,0));
      check("rst_cnt", cnt2, 0);
      check("rst_err", err[2], 0);
      check("rst_synced", synced[2], 0);

      for (int k = 0; k < 400; k++) begin
         fq = '0; fr = '0; fl = '0;
         if ($urandom_range(7) == 0) begin
            case ($urandom_range(2))
               0: fq[$urandom_range(7)*4 +: 4] = 4'($urandom_range(15, 1));
               1: fr[$urandom_range(7)] = 1'b1;
               default: fl[$urandom_range(7)] = 1'b1;
            endcase
         end
         v = mk($urandom_range(31) != 0, $urandom_range(63) == 0,
                $urandom_range(7) != 0, $urandom_range(15) == 0, 2'($urandom_range(3)),
                $urandom, g_pack() ^ fq, g_rco ^ fr, g_load ^ fl, 0, 0, 0);
         step(v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
